// File: rtl/cpu_multicycle.sv
// Multi-cycle core: one ALU and one register file shared across a control FSM,
// with request/ready handshakes on the instruction and data ports.
//   state  | meaning
//   FETCH  | request instruction at PC; on ready latch IR, PC <= PC+4
//   DECODE | read rs/rt into A/B
//   EXEC   | ALU op into ALUOut, ovf update, branch resolution
//   MEM    | hold load/store strobe until mem_ready
//   WB     | register write-back
//   HLT    | stopped, no requests, until reset
module cpu_multicycle #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int REG_COUNT  = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic [ADDR_WIDTH-1:0] instr_addr,
    output logic                  instr_req,
    input  logic [31:0]           instr,
    input  logic                  instr_ready,
    output logic [ADDR_WIDTH-1:0] data_addr,
    output logic [DATA_WIDTH-1:0] data_out,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic                  mem_read,
    output logic                  mem_write,
    input  logic                  mem_ready,
    output logic                  ovf,
    output logic                  halted
);
    localparam int         RIDX_W    = $clog2(REG_COUNT);
    localparam logic [5:0] REG_LIMIT = 6'(REG_COUNT);
    localparam int         MSB       = DATA_WIDTH - 1;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_HALT  = 6'b111111;

    localparam logic [2:0] F_ADD = 3'b000;
    localparam logic [2:0] F_SUB = 3'b001;
    localparam logic [2:0] F_AND = 3'b010;
    localparam logic [2:0] F_OR  = 3'b011;
    localparam logic [2:0] F_XOR = 3'b100;
    localparam logic [2:0] F_SLT = 3'b101;
    localparam logic [2:0] F_SLL = 3'b110;
    localparam logic [2:0] F_SRL = 3'b111;

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HLT
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [31:0]           ir_q, ir_d;
    logic [DATA_WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [DATA_WIDTH-1:0] alu_out_q, alu_out_d, mdr_q, mdr_d;
    logic                  ovf_q, ovf_d, halted_q, halted_d;
    logic                  instr_req_q, instr_req_d;
    logic                  mem_read_q, mem_read_d, mem_write_q, mem_write_d;
    logic [ADDR_WIDTH-1:0] data_addr_q, data_addr_d;
    logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
    logic [DATA_WIDTH-1:0] rf_q [REG_COUNT];

    logic [5:0]            op;
    logic [4:0]            rs, rt, rd;
    logic [2:0]            funct;
    logic signed [15:0]    imm;
    logic [DATA_WIDTH-1:0] imm_sext;
    logic [ADDR_WIDTH-1:0] br_off;

    assign op       = ir_q[31:26];
    assign rs       = ir_q[25:21];
    assign rt       = ir_q[20:16];
    assign rd       = ir_q[15:11];
    assign funct    = ir_q[2:0];
    assign imm      = ir_q[15:0];
    assign imm_sext = DATA_WIDTH'(imm);
    assign br_off   = ADDR_WIDTH'(imm) << 2;

    // Indices at or beyond REG_COUNT behave like r0: read 0, writes dropped.
    logic [DATA_WIDTH-1:0] rs_val, rt_val;
    always_comb begin
        rs_val = '0;
        rt_val = '0;
        if (rs != 5'd0 && {1'b0, rs} < REG_LIMIT) rs_val = rf_q[rs[RIDX_W-1:0]];
        if (rt != 5'd0 && {1'b0, rt} < REG_LIMIT) rt_val = rf_q[rt[RIDX_W-1:0]];
    end

    logic [DATA_WIDTH-1:0] alu_b, alu_res, sum, diff;
    logic                  alu_ovf, alu_sets_ovf, br_taken;
    always_comb begin
        alu_b        = (op == OP_RTYPE) ? b_q : imm_sext;
        sum          = a_q + alu_b;
        diff         = a_q - alu_b;
        alu_res      = sum;
        alu_ovf      = (a_q[MSB] == alu_b[MSB]) && (sum[MSB] != a_q[MSB]);
        alu_sets_ovf = (op == OP_ADDI);
        if (op == OP_RTYPE) begin
            alu_sets_ovf = (funct == F_ADD) || (funct == F_SUB);
            case (funct)
                F_SUB: begin
                    alu_res = diff;
                    alu_ovf = (a_q[MSB] != alu_b[MSB]) && (diff[MSB] != a_q[MSB]);
                end
                F_AND:   alu_res = a_q & alu_b;
                F_OR:    alu_res = a_q | alu_b;
                F_XOR:   alu_res = a_q ^ alu_b;
                F_SLT:   alu_res = {{(DATA_WIDTH-1){1'b0}}, ($signed(a_q) < $signed(alu_b))};
                F_SLL:   alu_res = a_q << alu_b[4:0];
                F_SRL:   alu_res = a_q >> alu_b[4:0];
                default: alu_res = sum;
            endcase
        end
        br_taken = (op == OP_BEQ) ? (a_q == b_q) : (a_q != b_q);
    end

    logic                  rf_we;
    logic [4:0]            rf_waddr;
    logic [DATA_WIDTH-1:0] rf_wdata;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        ir_d        = ir_q;
        a_d         = a_q;
        b_d         = b_q;
        alu_out_d   = alu_out_q;
        mdr_d       = mdr_q;
        ovf_d       = ovf_q;
        halted_d    = halted_q;
        instr_req_d = instr_req_q;
        mem_read_d  = mem_read_q;
        mem_write_d = mem_write_q;
        data_addr_d = data_addr_q;
        data_out_d  = data_out_q;
        rf_we       = 1'b0;
        rf_waddr    = (op == OP_RTYPE) ? rd : rt;
        rf_wdata    = (op == OP_LW) ? mdr_q : alu_out_q;

        case (state_q)
            S_FETCH: begin
                if (instr_req_q && instr_ready) begin
                    ir_d        = instr;
                    pc_d        = pc_q + ADDR_WIDTH'(4);
                    instr_req_d = 1'b0;
                    state_d     = S_DECODE;
                end else begin
                    instr_req_d = 1'b1;
                end
            end
            S_DECODE: begin
                a_d = rs_val;
                b_d = rt_val;
                case (op)
                    OP_HALT: begin
                        state_d  = S_HLT;
                        halted_d = 1'b1;
                    end
                    OP_RTYPE, OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_BNE: state_d = S_EXEC;
                    default: begin
                        state_d     = S_FETCH;
                        instr_req_d = 1'b1;
                    end
                endcase
            end
            S_EXEC: begin
                alu_out_d = alu_res;
                if (alu_sets_ovf) ovf_d = alu_ovf;
                case (op)
                    OP_BEQ, OP_BNE: begin
                        // pc_q already holds the address of the next instruction
                        if (br_taken) pc_d = pc_q + br_off;
                        state_d     = S_FETCH;
                        instr_req_d = 1'b1;
                    end
                    OP_LW, OP_SW: begin
                        state_d     = S_MEM;
                        mem_read_d  = (op == OP_LW);
                        mem_write_d = (op == OP_SW);
                        data_addr_d = ADDR_WIDTH'(alu_res);
                        if (op == OP_SW) data_out_d = b_q;
                    end
                    default: state_d = S_WB;
                endcase
            end
            S_MEM: begin
                if (mem_ready) begin
                    mem_read_d  = 1'b0;
                    mem_write_d = 1'b0;
                    if (mem_read_q) begin
                        mdr_d   = data_in;
                        state_d = S_WB;
                    end else begin
                        state_d     = S_FETCH;
                        instr_req_d = 1'b1;
                    end
                end
            end
            S_WB: begin
                rf_we       = (rf_waddr != 5'd0) && ({1'b0, rf_waddr} < REG_LIMIT);
                state_d     = S_FETCH;
                instr_req_d = 1'b1;
            end
            S_HLT: ;
            default: state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_FETCH;
            pc_q        <= RESET_PC;
            ir_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            alu_out_q   <= '0;
            mdr_q       <= '0;
            ovf_q       <= 1'b0;
            halted_q    <= 1'b0;
            instr_req_q <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            data_addr_q <= '0;
            data_out_q  <= '0;
            for (int i = 0; i < REG_COUNT; i++) rf_q[i] <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            ir_q        <= ir_d;
            a_q         <= a_d;
            b_q         <= b_d;
            alu_out_q   <= alu_out_d;
            mdr_q       <= mdr_d;
            ovf_q       <= ovf_d;
            halted_q    <= halted_d;
            instr_req_q <= instr_req_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            data_addr_q <= data_addr_d;
            data_out_q  <= data_out_d;
            if (rf_we) rf_q[rf_waddr[RIDX_W-1:0]] <= rf_wdata;
        end
    end

    assign instr_addr = pc_q;
    assign instr_req  = instr_req_q;
    assign data_addr  = data_addr_q;
    assign data_out   = data_out_q;
    assign mem_read   = mem_read_q;
    assign mem_write  = mem_write_q;
    assign ovf        = ovf_q;
    assign halted     = halted_q;

endmodule

// File: tb/tb_cpu_multicycle.sv
// Directed bench for cpu_multicycle: a default 32-bit core with programmable
// ready delays, plus a 16-bit / 8-register core started at a non-zero PC.
module tb_cpu_multicycle;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [31:0] instr_addr_a, instr_a, data_addr_a, data_out_a, data_in_a;
    logic        instr_req_a, instr_ready_a, mem_read_a, mem_write_a, mem_ready_a, ovf_a, halted_a;
    logic [15:0] instr_addr_b, data_addr_b, data_out_b, data_in_b;
    logic [31:0] instr_b;
    logic        instr_req_b, mem_read_b, mem_write_b, ovf_b, halted_b;

    logic [31:0] imem_a [64];
    logic [31:0] dmem_a [64];
    logic [31:0] imem_b [64];

    int mem_delay = 0, instr_delay = 0, mcnt = 0, icnt = 0, cyc = 0;
    int wr_cycles = 0, rd_cycles = 0, strobe_viol = 0, halt_cyc = 0;
    logic halt_seen = 1'b0;
    logic [31:0] wr_addr = '0, wr_data = '0;
    logic [31:0] fa_addr [$];
    int          fa_cyc  [$];
    logic        fa_ovf  [$];

    int n_pass = 0, n_total = 0, base = 0;

    cpu_multicycle dut_a (
        .clk(clk), .rst(rst),
        .instr_addr(instr_addr_a), .instr_req(instr_req_a), .instr(instr_a), .instr_ready(instr_ready_a),
        .data_addr(data_addr_a), .data_out(data_out_a), .data_in(data_in_a),
        .mem_read(mem_read_a), .mem_write(mem_write_a), .mem_ready(mem_ready_a),
        .ovf(ovf_a), .halted(halted_a)
    );

    cpu_multicycle #(.DATA_WIDTH(16), .ADDR_WIDTH(16), .REG_COUNT(8), .RESET_PC(16'h0040)) dut_b (
        .clk(clk), .rst(rst),
        .instr_addr(instr_addr_b), .instr_req(instr_req_b), .instr(instr_b), .instr_ready(1'b1),
        .data_addr(data_addr_b), .data_out(data_out_b), .data_in(data_in_b),
        .mem_read(mem_read_b), .mem_write(mem_write_b), .mem_ready(1'b1),
        .ovf(ovf_b), .halted(halted_b)
    );

    assign instr_a       = imem_a[instr_addr_a[7:2]];
    assign instr_ready_a = instr_req_a && (icnt >= instr_delay);
    assign mem_ready_a   = (mem_read_a || mem_write_a) && (mcnt >= mem_delay);
    assign data_in_a     = dmem_a[data_addr_a[7:2]];
    assign instr_b       = imem_b[instr_addr_b[7:2]];
    assign data_in_b     = 16'h0;

    always @(posedge clk) begin
        cyc  <= cyc + 1;
        icnt <= (instr_req_a && !instr_ready_a) ? icnt + 1 : 0;
        mcnt <= ((mem_read_a || mem_write_a) && !mem_ready_a) ? mcnt + 1 : 0;
        if (mem_write_a && mem_ready_a) dmem_a[data_addr_a[7:2]] <= data_out_a;
        if (mem_write_a) begin
            wr_cycles <= wr_cycles + 1;
            wr_addr   <= data_addr_a;
            wr_data   <= data_out_a;
        end
        if (mem_read_a) rd_cycles <= rd_cycles + 1;
        if ((mem_read_a && mem_write_a) || (instr_req_a && (mem_read_a || mem_write_a)))
            strobe_viol <= strobe_viol + 1;
        if (!rst && instr_req_a && instr_ready_a) begin
            fa_addr.push_back(instr_addr_a);
            fa_cyc.push_back(cyc);
            fa_ovf.push_back(ovf_a);
        end
        if (rst) halt_seen <= 1'b0;
        else if (halted_a && !halt_seen) begin
            halt_seen <= 1'b1;
            halt_cyc  <= cyc;
        end
    end

    function automatic logic [31:0] r_ins(input int rs, input int rt, input int rd, input int fn);
        return {6'b0, 5'(rs), 5'(rt), 5'(rd), 8'b0, 3'(fn)};
    endfunction

    function automatic logic [31:0] i_ins(input int op, input int rs, input int rt, input int imm);
        return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic wait_halt(input int bound, input string tag);
        int n = 0;
        while (!halted_a && n < bound) begin
            tick(1);
            n++;
        end
        chk(tag, 32'(halted_a), 32'd1);
    endtask

    task automatic clear_imem_a();
        for (int i = 0; i < 64; i++) imem_a[i] = i_ins(6'h3F, 0, 0, 0);
    endtask

    initial begin
        logic [31:0] exp_addr [8];
        int          exp_d    [7];
        logic [31:0] exp_r    [16];

        rst = 1'b1;
        clear_imem_a();
        for (int i = 0; i < 64; i++) imem_b[i] = i_ins(6'h3F, 0, 0, 0);

        // program 1: arithmetic, store/load with slow memory, branches, halt
        imem_a[0] = i_ins(6'h08, 0, 1, 5);
        imem_a[1] = i_ins(6'h08, 0, 2, -3);
        imem_a[2] = r_ins(1, 2, 3, 0);
        imem_a[3] = i_ins(6'h2B, 0, 1, 8);
        imem_a[4] = i_ins(6'h04, 1, 1, 2);
        imem_a[5] = i_ins(6'h08, 0, 7, 1);
        imem_a[6] = i_ins(6'h08, 0, 7, 2);
        imem_a[7] = i_ins(6'h05, 1, 1, 2);
        imem_a[8] = i_ins(6'h23, 0, 4, 8);
        imem_a[9] = i_ins(6'h3F, 0, 0, 0);

        // narrow core starting at 0x40
        imem_b[16] = i_ins(6'h08, 0, 1, 1);
        imem_b[17] = i_ins(6'h08, 0, 9, 5);
        imem_b[18] = r_ins(9, 0, 2, 0);
        imem_b[19] = i_ins(6'h08, 0, 3, 15);
        imem_b[20] = r_ins(1, 3, 4, 6);
        imem_b[21] = r_ins(4, 4, 5, 0);
        imem_b[22] = i_ins(6'h3F, 0, 0, 0);

        mem_delay = 3;
        tick(2);
        chk("rst_instr_req", 32'(instr_req_a), 32'd0);
        chk("rst_mem_read", 32'(mem_read_a), 32'd0);
        chk("rst_mem_write", 32'(mem_write_a), 32'd0);
        chk("rst_data_addr", data_addr_a, 32'd0);
        chk("rst_data_out", data_out_a, 32'd0);
        chk("rst_halted", 32'(halted_a), 32'd0);
        chk("rst_ovf", 32'(ovf_a), 32'd0);
        chk("rst_pc", instr_addr_a, 32'd0);
        chk("rst_pc_b", 32'(instr_addr_b), 32'h40);

        base = fa_addr.size();
        rst  = 1'b0;
        wait_halt(300, "p1_halt");
        tick(20);
        exp_addr = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h1C, 32'h20, 32'h24};
        exp_d    = '{4, 4, 4, 7, 3, 3, 8};
        for (int k = 0; k < 8; k++) chk($sformatf("p1_fetch_addr%0d", k), fa_addr[base+k], exp_addr[k]);
        for (int k = 1; k < 8; k++)
            chk($sformatf("p1_fetch_delta%0d", k), 32'(fa_cyc[base+k] - fa_cyc[base+k-1]), 32'(exp_d[k-1]));
        chk("p1_no_fetch_after_halt", 32'(fa_addr.size() - base), 32'd8);
        chk("p1_halt_latency", 32'(halt_cyc - fa_cyc[base+7]), 32'd2);
        chk("p1_instr_req_halted", 32'(instr_req_a), 32'd0);
        chk("p1_r1", dut_a.rf_q[1], 32'd5);
        chk("p1_r2", dut_a.rf_q[2], 32'hFFFF_FFFD);
        chk("p1_r3", dut_a.rf_q[3], 32'd2);
        chk("p1_r4", dut_a.rf_q[4], 32'd5);
        chk("p1_r7_skipped", dut_a.rf_q[7], 32'd0);
        chk("p1_sw_cycles", 32'(wr_cycles), 32'd4);
        chk("p1_sw_addr", wr_addr, 32'd8);
        chk("p1_sw_data", wr_data, 32'd5);
        chk("p1_lw_cycles", 32'(rd_cycles), 32'd4);
        chk("p1_ovf", 32'(ovf_a), 32'd0);

        chk("b_halted", 32'(halted_b), 32'd1);
        chk("b_pc", 32'(instr_addr_b), 32'h5C);
        chk("b_r1", 32'(dut_b.rf_q[1]), 32'd1);
        chk("b_r9_reads_zero", 32'(dut_b.rf_q[2]), 32'd0);
        chk("b_sll15", 32'(dut_b.rf_q[4]), 32'h8000);
        chk("b_add_wrap", 32'(dut_b.rf_q[5]), 32'd0);
        chk("b_ovf", 32'(ovf_b), 32'd1);

        // program 2: ALU functions, overflow flag, r0, NOP, slow fetch
        rst = 1'b1;
        clear_imem_a();
        imem_a[0]  = i_ins(6'h08, 0, 1, 1);
        imem_a[1]  = i_ins(6'h08, 0, 5, -1);
        imem_a[2]  = r_ins(5, 1, 5, 7);
        imem_a[3]  = i_ins(6'h08, 0, 6, 1);
        imem_a[4]  = r_ins(5, 6, 7, 0);
        imem_a[5]  = r_ins(5, 6, 8, 2);
        imem_a[6]  = r_ins(6, 6, 9, 0);
        imem_a[7]  = r_ins(7, 6, 10, 1);
        imem_a[8]  = r_ins(7, 6, 11, 5);
        imem_a[9]  = r_ins(5, 7, 12, 4);
        imem_a[10] = r_ins(7, 1, 13, 3);
        imem_a[11] = r_ins(12, 1, 14, 6);
        imem_a[12] = i_ins(6'h08, 0, 0, 7);
        imem_a[13] = r_ins(0, 1, 15, 0);
        imem_a[14] = i_ins(6'h01, 0, 0, 0);
        imem_a[15] = i_ins(6'h3F, 0, 0, 0);
        mem_delay   = 0;
        instr_delay = 1;
        tick(2);
        base = fa_addr.size();
        rst  = 1'b0;
        wait_halt(400, "p2_halt");
        tick(5);
        exp_r = '{32'h0, 32'h1, 32'h0, 32'h0, 32'h0, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000,
                  32'h1, 32'h2, 32'h7FFF_FFFF, 32'h1, 32'hFFFF_FFFF, 32'h8000_0001, 32'hFFFF_FFFE, 32'h1};
        for (int r = 5; r < 16; r++) chk($sformatf("p2_r%0d", r), dut_a.rf_q[r], exp_r[r]);
        chk("p2_ovf_after_addi_neg", 32'(fa_ovf[base+2]), 32'd0);
        chk("p2_ovf_add_overflow", 32'(fa_ovf[base+5]), 32'd1);
        chk("p2_ovf_and_keeps", 32'(fa_ovf[base+6]), 32'd1);
        chk("p2_ovf_add_clears", 32'(fa_ovf[base+7]), 32'd0);
        chk("p2_ovf_sub_overflow", 32'(fa_ovf[base+8]), 32'd1);
        chk("p2_ovf_slt_keeps", 32'(fa_ovf[base+9]), 32'd1);
        chk("p2_addi_delta_slow_fetch", 32'(fa_cyc[base+4] - fa_cyc[base+3]), 32'd5);
        chk("p2_nop_delta_slow_fetch", 32'(fa_cyc[base+15] - fa_cyc[base+14]), 32'd3);
        chk("p2_fetch_count", 32'(fa_addr.size() - base), 32'd16);

        // program 3: reset while a load is stalled
        rst = 1'b1;
        clear_imem_a();
        imem_a[0] = i_ins(6'h08, 0, 1, 9);
        imem_a[1] = i_ins(6'h23, 0, 2, 8);
        imem_a[2] = i_ins(6'h3F, 0, 0, 0);
        instr_delay = 0;
        mem_delay   = 1000;
        tick(2);
        rst = 1'b0;
        begin
            int n = 0;
            while (!mem_read_a && n < 50) begin
                tick(1);
                n++;
            end
        end
        chk("p3_lw_issued", 32'(mem_read_a), 32'd1);
        tick(3);
        chk("p3_lw_stalled", 32'(mem_read_a), 32'd1);
        chk("p3_lw_addr", data_addr_a, 32'd8);
        rst = 1'b1;
        tick(1);
        chk("p3_rst_mem_read", 32'(mem_read_a), 32'd0);
        chk("p3_rst_instr_req", 32'(instr_req_a), 32'd0);
        chk("p3_rst_pc", instr_addr_a, 32'd0);
        chk("p3_rst_r2", dut_a.rf_q[2], 32'd0);
        chk("p3_rst_halted", 32'(halted_a), 32'd0);
        mem_delay = 0;
        base = fa_addr.size();
        rst  = 1'b0;
        wait_halt(200, "p3_halt");
        chk("p3_refetch_addr", fa_addr[base], 32'd0);
        chk("p3_r1", dut_a.rf_q[1], 32'd9);
        chk("p3_r2_load", dut_a.rf_q[2], 32'd5);

        chk("strobe_exclusive", 32'(strobe_viol), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
